// File: rtl/info_disp_pkg.sv
// Shared definitions for the info-text display scheduler.
//   - Glyph codes, matching the on-screen glyph table.
//   - Cell/bank types (glyph_t, cells_t).
//   - Scheduler state enum.
//   - Sizing constants.
//   - reset_glyph(): the idle/reset content of a cell.
package info_disp_pkg;

  localparam int CELLS       = 8;
  localparam int BCD_DIGITS  = 10;
  localparam int CONV_CYCLES = 34;  // LOAD + 32 SHIFT + FORMAT per channel

  typedef logic [4:0] glyph_t;
  typedef glyph_t cells_t [CELLS];

  localparam glyph_t DIG_DP    = 5'd10;
  localparam glyph_t ENG_KILO  = 5'd11;
  localparam glyph_t ENG_NONE  = 5'd12;
  localparam glyph_t DIG_BLANK = 5'd16;
  localparam glyph_t ENG_MEGA  = 5'd16;  // "M" shares the blank slot in the glyph table
  localparam glyph_t UNIT_VOLT = 5'd13;
  localparam glyph_t UNIT_HZ   = 5'd21;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_FORMAT,
    ST_DONE
  } sched_state_t;

  // Idle content of cell k:
  //   - cell 3 shows the decimal point;
  //   - cell 7 shows the channel unit;
  //   - every other cell is blank.
  function automatic glyph_t reset_glyph(input int k, input glyph_t unit);
    if (k == 3)      return DIG_DP;
    else if (k == 7) return unit;
    else             return DIG_BLANK;
  endfunction

endpackage

// File: rtl/info_display_scheduler_bin2bcd.sv
// bin2bcd_seq: iterative 32-bit binary to 10-digit BCD converter (double dabble).
// Ports:
//   clk, rst  clock, synchronous active-high reset
//   start     load 'value' and clear the BCD accumulator
//   value     32-bit binary input, sampled when start=1
//   done      high during the cycle that performs the final (32nd) shift step;
//             'bcd' holds the result from the following cycle until the next start
//   bcd       10 BCD digits, digit i (i=0 is the ones digit) in bits [4i+3:4i]
module bin2bcd_seq
  import info_disp_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [31:0]             value,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  logic [31:0]             bin_q;
  logic [4*BCD_DIGITS-1:0] bcd_q;
  logic [4*BCD_DIGITS-1:0] adj;
  logic [4:0]              iter_q;
  logic                    run_q;

  // Add-3 correction on every nibble >= 5 before the shift.
  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      iter_q <= '0;
      run_q  <= 1'b0;
    end else if (start) begin
      bin_q  <= value;
      bcd_q  <= '0;
      iter_q <= '0;
      run_q  <= 1'b1;
    end else if (run_q) begin
      bcd_q  <= {adj[4*BCD_DIGITS-2:0], bin_q[31]};
      bin_q  <= {bin_q[30:0], 1'b0};
      iter_q <= iter_q + 5'd1;
      if (iter_q == 5'd31) run_q <= 1'b0;
    end
  end

  assign done = run_q && (iter_q == 5'd31);
  assign bcd  = bcd_q;

endmodule

// File: rtl/info_display_scheduler.sv
// info_display_scheduler: converts N_CH 32-bit measurements into glyph cells once per frame.
// Each channel is shown as:
//   - a 3.2-digit read-out;
//   - an engineering prefix;
//   - a unit glyph.
// The work is done by one shared sequential BCD converter.
// Optional feature, enabled by the macro INFO_SCHED_HOLD_EN:
//   - adds input 'hold';
//   - while hold=1, frame ticks neither start a sequence nor set pending.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   frame_tick   single-cycle start-of-frame pulse
//   hold         (INFO_SCHED_HOLD_EN only) freeze the display
//   value_in     N_CH x 32-bit measurements, channel c in [32c+31:32c]
//   digit_out    N_CH x 8 cells x 5 bits, cell k of channel c in [40c+5k+4:40c+5k]
//   busy         a conversion sequence is in progress (low in the DONE cycle)
//   update_done  one-cycle pulse after the last channel has been written
// Handshake: frame_tick is a fire-and-forget request. A tick arriving while
//   busy, or during the DONE cycle, is remembered as a single pending restart.
module info_display_scheduler
  import info_disp_pkg::*;
#(
  parameter int                N_CH       = 4,
  parameter logic [N_CH*5-1:0] UNIT_CODES = {N_CH{5'd13}}
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
`ifdef INFO_SCHED_HOLD_EN
  input  logic               hold,
`endif
  input  logic [N_CH*32-1:0] value_in,
  output logic [N_CH*40-1:0] digit_out,
  output logic               busy,
  output logic               update_done
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

  sched_state_t            state, state_next;
  logic [31:0]             snap [N_CH];
  logic [CH_W-1:0]         ch_q;
  logic                    pending_q;
  cells_t                  bank [N_CH];

  logic                    tick_ok;
  logic                    latch_snap;
  logic                    conv_start;
  logic                    conv_done;
  logic                    fmt_we;
  logic                    ch_inc;
  logic [4*BCD_DIGITS-1:0] conv_bcd;
  cells_t                  fmt_cells;
  glyph_t                  unit_sel;

`ifdef INFO_SCHED_HOLD_EN
  assign tick_ok = frame_tick & ~hold;
`else
  assign tick_ok = frame_tick;
`endif

  bin2bcd_seq u_conv (
    .clk   (clk),
    .rst   (rst),
    .start (conv_start),
    .value (snap[ch_q]),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  // Next-state and control decode.
  always_comb begin
    state_next = state;
    latch_snap = 1'b0;
    conv_start = 1'b0;
    fmt_we     = 1'b0;
    ch_inc     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (tick_ok) begin
          latch_snap = 1'b1;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        conv_start = 1'b1;
        state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (conv_done) state_next = ST_FORMAT;
      end
      ST_FORMAT: begin
        fmt_we = 1'b1;
        if (ch_q == LAST_CH) begin
          state_next = ST_DONE;
        end else begin
          ch_inc     = 1'b1;
          state_next = ST_LOAD;
        end
      end
      ST_DONE: begin
        // A tick landing in this very cycle counts the same as a pending one.
        if (pending_q || tick_ok) begin
          latch_snap = 1'b1;
          state_next = ST_LOAD;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign busy        = (state == ST_LOAD) || (state == ST_SHIFT) || (state == ST_FORMAT);
  assign update_done = (state == ST_DONE);

  always_comb begin
    unit_sel = UNIT_CODES[4:0];
    for (int c = 0; c < N_CH; c++) begin
      if (ch_q == CH_W'(c)) unit_sel = UNIT_CODES[5*c +: 5];
    end
  end

  // Range selection and leading-zero blanking on the finished BCD word.
  // sel[0..4] are the five shown digits, most significant first.
  always_comb begin
    logic [3:0] d   [BCD_DIGITS];
    logic [3:0] sel [5];
    glyph_t     eng;
    for (int i = 0; i < BCD_DIGITS; i++) d[i] = conv_bcd[4*i +: 4];
    if (d[9] != 4'd0) begin
      for (int i = 0; i < 5; i++) sel[i] = 4'd9;
      eng = ENG_MEGA;
    end else if ((d[8] | d[7] | d[6]) != 4'd0) begin
      sel = '{d[8], d[7], d[6], d[5], d[4]};
      eng = ENG_MEGA;
    end else if ((d[5] | d[4] | d[3]) != 4'd0) begin
      sel = '{d[5], d[4], d[3], d[2], d[1]};
      eng = ENG_KILO;
    end else begin
      sel = '{d[2], d[1], d[0], 4'd0, 4'd0};
      eng = ENG_NONE;
    end
    fmt_cells[0] = (sel[0] == 4'd0) ? DIG_BLANK : {1'b0, sel[0]};
    fmt_cells[1] = (sel[0] == 4'd0 && sel[1] == 4'd0) ? DIG_BLANK : {1'b0, sel[1]};
    fmt_cells[2] = {1'b0, sel[2]};
    fmt_cells[3] = DIG_DP;
    fmt_cells[4] = {1'b0, sel[3]};
    fmt_cells[5] = {1'b0, sel[4]};
    fmt_cells[6] = eng;
    fmt_cells[7] = unit_sel;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ch_q      <= '0;
      pending_q <= 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        snap[c] <= '0;
        for (int k = 0; k < CELLS; k++) begin
          bank[c][k] <= reset_glyph(k, UNIT_CODES[5*c +: 5]);
        end
      end
    end else begin
      state <= state_next;
      if (latch_snap) begin
        for (int c = 0; c < N_CH; c++) snap[c] <= value_in[32*c +: 32];
        ch_q <= '0;
      end else if (ch_inc) begin
        ch_q <= ch_q + 1'b1;
      end
      // DONE consumes the pending request; ticks while busy collapse into one.
      if (state == ST_DONE)      pending_q <= 1'b0;
      else if (busy && tick_ok)  pending_q <= 1'b1;
      if (fmt_we) bank[ch_q] <= fmt_cells;
    end
  end

  always_comb begin
    digit_out = '0;
    for (int c = 0; c < N_CH; c++) begin
      for (int k = 0; k < CELLS; k++) begin
        digit_out[40*c + 5*k +: 5] = bank[c][k];
      end
    end
  end

endmodule

// File: tb/tb_info_display_scheduler.sv
module tb_info_display_scheduler;

  localparam int N_CH  = 4;
  localparam int SEQ   = 34 * N_CH;  // edge of the last channel write, relative to the start edge
  localparam logic [N_CH*5-1:0] UNITS = {5'd21, 5'd13, 5'd21, 5'd13};

  logic               clk = 1'b0;
  logic               rst;
  logic               frame_tick;
  logic               hold;
  logic [N_CH*32-1:0] value_in;
  logic [N_CH*40-1:0] digit_out;
  logic               busy;
  logic               update_done;

  int total = 0;
  int bad   = 0;

  logic [N_CH*40-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  info_display_scheduler #(.N_CH(N_CH), .UNIT_CODES(UNITS)) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_tick  (frame_tick),
`ifdef INFO_SCHED_HOLD_EN
    .hold        (hold),
`endif
    .value_in    (value_in),
    .digit_out   (digit_out),
    .busy        (busy),
    .update_done (update_done)
  );

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [N_CH*40-1:0] act, input logic [N_CH*40-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] lit8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    return {5'(a7), 5'(a6), 5'(a5), 5'(a4), 5'(a3), 5'(a2), 5'(a1), 5'(a0)};
  endfunction

  function automatic logic [4:0] unit_of(input int c);
    return UNITS[5*c +: 5];
  endfunction

  // Expected cells of one channel, computed with plain arithmetic.
  // n holds the five shown digits: cells 0,1,2 then 4,5.
  function automatic logic [39:0] fmt_ref(input logic [31:0] v, input logic [4:0] unit);
    longint x, n;
    int     dg[5];
    int     eng;
    int     c0, c1;
    x = longint'(v);
    if (x >= 64'd1000000000)   begin n = 99999;        eng = 16; end
    else if (x >= 64'd1000000) begin n = x / 10000;    eng = 16; end
    else if (x >= 64'd1000)    begin n = x / 10;       eng = 11; end
    else                       begin n = x * 100;      eng = 12; end
    dg[0] = int'((n / 10000) % 10);
    dg[1] = int'((n / 1000) % 10);
    dg[2] = int'((n / 100) % 10);
    dg[3] = int'((n / 10) % 10);
    dg[4] = int'(n % 10);
    c0 = (dg[0] == 0) ? 16 : dg[0];
    c1 = (dg[0] == 0 && dg[1] == 0) ? 16 : dg[1];
    return lit8(c0, c1, dg[2], 10, dg[3], dg[4], eng, int'(unit));
  endfunction

  function automatic logic [N_CH*40-1:0] reset_ref();
    logic [N_CH*40-1:0] r;
    for (int c = 0; c < N_CH; c++) r[40*c +: 40] = lit8(16, 16, 16, 10, 16, 16, 16, int'(unit_of(c)));
    return r;
  endfunction

  // ---------------- behavioural model + per-cycle compare ----------------
  // A sequence started at edge t0 writes channel c at edge t0+34(c+1).
  // It reports done in the cycle after edge t0+SEQ.
  // At edge t0+SEQ+1 it either restarts (pending or tick) or goes idle.
  int                 cyc = 0;
  int                 m_t0 = 0;
  bit                 m_active = 0;
  bit                 m_pend = 0;
  logic [31:0]        m_snap [N_CH];
  logic [N_CH*40-1:0] m_digits;

  always @(posedge clk) begin
    bit tick_eff;
    int k;
    bit e_busy, e_done;
`ifdef INFO_SCHED_HOLD_EN
    tick_eff = frame_tick && !hold;
`else
    tick_eff = frame_tick;
`endif
    if (rst) begin
      m_digits = reset_ref();
      m_active = 0;
      m_pend   = 0;
    end else if (m_active) begin
      k = cyc - m_t0;
      if (k >= 34 && k <= SEQ && (k % 34) == 0)
        m_digits[40*(k/34 - 1) +: 40] = fmt_ref(m_snap[k/34 - 1], unit_of(k/34 - 1));
      if (k == SEQ + 1) begin
        if (m_pend || tick_eff) begin
          m_t0 = cyc;
          for (int c = 0; c < N_CH; c++) m_snap[c] = value_in[32*c +: 32];
        end else begin
          m_active = 0;
        end
        m_pend = 0;
      end else if (tick_eff) begin
        m_pend = 1;
      end
    end else if (tick_eff) begin
      m_active = 1;
      m_t0     = cyc;
      for (int c = 0; c < N_CH; c++) m_snap[c] = value_in[32*c +: 32];
    end
    k      = cyc - m_t0;
    e_busy = m_active && (k < SEQ);
    e_done = m_active && (k == SEQ);
    cyc++;
    #1;
    check("busy", {{(N_CH*40-1){1'b0}}, busy}, {{(N_CH*40-1){1'b0}}, e_busy});
    check("update_done", {{(N_CH*40-1){1'b0}}, update_done}, {{(N_CH*40-1){1'b0}}, e_done});
    check("digit_out", digit_out, m_digits);
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_tick();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  // Cycles (counted from the tick edge) until update_done is seen; bounded.
  task automatic wait_done(output int cnt);
    cnt = 1;
    while (!update_done && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  function automatic logic [31:0] rand_val();
    logic [31:0] bnd [8];
    bnd = '{32'd0, 32'd999, 32'd1000, 32'd999999, 32'd1000000,
            32'd999999999, 32'd1000000000, 32'hFFFF_FFFF};
    case ($urandom_range(0, 5))
      0:       return 32'($urandom_range(0, 999));
      1:       return 32'($urandom_range(1000, 999999));
      2:       return 32'($urandom_range(1000000, 999999999));
      3:       return 32'($urandom);
      4:       return bnd[$urandom_range(0, 7)];
      default: return 32'($urandom_range(0, 9));
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int cnt, pulses, gaps;
    logic [N_CH*40-1:0] saved;
    rst        = 1'b1;
    frame_tick = 1'b0;
    hold       = 1'b0;
    value_in   = '0;
    repeat (3) @(negedge clk);
    check("reset_pattern", digit_out, reset_ref());
    rst = 1'b0;
    @(negedge clk);

    // Pin the model on hand-computed read-outs.
    check("model_5",     {120'd0, fmt_ref(32'd5, 5'd13)},       {120'd0, lit8(16, 16, 5, 10, 0, 0, 12, 13)});
    check("model_1234",  {120'd0, fmt_ref(32'd1234, 5'd21)},    {120'd0, lit8(16, 16, 1, 10, 2, 3, 11, 21)});
    check("model_1e6",   {120'd0, fmt_ref(32'd1000000, 5'd13)}, {120'd0, lit8(16, 16, 1, 10, 0, 0, 16, 13)});
    check("model_sat",   {120'd0, fmt_ref(32'hFFFF_FFFF, 5'd21)}, {120'd0, lit8(9, 9, 9, 10, 9, 9, 16, 21)});

    // Frame 1: mixed ranges; value_in scrambled mid-conversion.
    value_in = {32'hFFFF_FFFF, 32'd999999, 32'd1234, 32'd5};
    exp_q.push_back({lit8(9, 9, 9, 10, 9, 9, 16, 21), lit8(9, 9, 9, 10, 9, 9, 11, 13),
                     lit8(16, 16, 1, 10, 2, 3, 11, 21), lit8(16, 16, 5, 10, 0, 0, 12, 13)});
    pulse_tick();
    cnt = 1;
    while (!update_done && cnt < 1000) begin
      @(negedge clk);
      cnt++;
      if (cnt == 35) check("ch0_at_35", {120'd0, digit_out[39:0]}, {120'd0, lit8(16, 16, 5, 10, 0, 0, 12, 13)});
      if (cnt == 40) value_in = {4{32'd7777777}};
    end
    check("done_latency", N_CH*40'(cnt), N_CH*40'(137));
    check("frame1_cells", digit_out, exp_q.pop_front());

    // Frame 2: mega boundary on ch0.
    value_in[31:0] = 32'd1000000;
    pulse_tick();
    wait_done(cnt);
    check("ch0_1e6", {120'd0, digit_out[39:0]}, {120'd0, lit8(16, 16, 1, 10, 0, 0, 16, 13)});
    @(negedge clk);

    // Back-to-back ticks: second and third collapse into one restart.
    pulse_tick();
    repeat (9) @(negedge clk);
    value_in = {32'd42, 32'd4200, 32'd420000, 32'd42000000};
    pulse_tick();
    repeat (30) @(negedge clk);
    pulse_tick();
    pulses = 0;
    gaps   = 0;
    repeat (350) begin
      @(negedge clk);
      if (update_done) pulses++;
      else if (!busy && pulses < 2) gaps++;
    end
    check("restart_pulses", N_CH*40'(pulses), N_CH*40'(2));
    check("restart_gaps", N_CH*40'(gaps), N_CH*40'(0));

    // Reset in the middle of a sequence.
    pulse_tick();
    repeat (48) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_reset_cells", digit_out, reset_ref());
    check("mid_reset_busy", {159'd0, busy}, 160'd0);
    repeat (3) @(negedge clk);

`ifdef INFO_SCHED_HOLD_EN
    value_in = {32'd1, 32'd2, 32'd3, 32'd4};
    saved    = digit_out;
    hold     = 1'b1;
    pulse_tick();
    repeat (5) @(negedge clk);
    check("hold_busy", {159'd0, busy}, 160'd0);
    check("hold_cells", digit_out, saved);
    hold = 1'b0;
    pulse_tick();
    wait_done(cnt);
    check("unhold_ch0", {120'd0, digit_out[39:0]}, {120'd0, lit8(16, 16, 4, 10, 0, 0, 12, 13)});
    @(negedge clk);
`else
    saved = digit_out;
`endif

    // Randomized traffic against the model.
    repeat (4000) begin
      for (int c = 0; c < N_CH; c++) value_in[32*c +: 32] = rand_val();
      frame_tick = ($urandom_range(0, 59) == 0);
      rst        = ($urandom_range(0, 1499) == 0);
`ifdef INFO_SCHED_HOLD_EN
      if ($urandom_range(0, 199) == 0) hold = ~hold;
`endif
      @(negedge clk);
    end
    frame_tick = 1'b0;
    rst        = 1'b0;
    hold       = 1'b0;
    repeat (300) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
